// File: rtl/top2_frame_sched_pkg.sv
// Shared types and defaults for the frame scheduler and its top-2 tracker.
package top2_frame_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 16;
    localparam int NREQ_DEF  = 4;
    localparam int CNTW_DEF  = 8;

    // Bits needed to index n requesters; never less than 1.
    function automatic int id_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/top2_tracker.sv
// Streaming largest / second-largest tracker with a saturating beat counter.
module top2_tracker
    import top2_frame_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             valid,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] second,
    output logic [CNTW-1:0]  count
);

    // Clear wins over a beat; duplicates are treated as distinct elements,
    // so the second beat always seeds 'second' when it does not beat 'max'.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            max    <= '0;
            second <= '0;
            count  <= '0;
        end else if (valid) begin
            if (count == '0) begin
                max <= x;
            end else if (x > max) begin
                second <= max;
                max    <= x;
            end else if ((x > second) || (count == CNTW'(1))) begin
                second <= x;
            end
            if (count != '1) count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/top2_frame_sched.sv
// Round-robin frame scheduler sharing one top-2 tracker between requesters.
module top2_frame_sched
    import top2_frame_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREQ  = NREQ_DEF,
    parameter int IDW   = id_width(NREQ),
    parameter int CNTW  = CNTW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             din_ready,
    output logic [WIDTH-1:0] result,
    output logic [IDW-1:0]   result_id,
    output logic [CNTW-1:0]  result_cnt,
    output logic             result_err,
    output logic             result_valid
);

    state_t           state, state_nx;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gidx;
    logic [IDW-1:0]   pick;
    logic             aborted;
    logic             beat;
    logic             last_beat;
    logic             req_drop;

    logic [WIDTH-1:0] trk_max;
    logic [WIDTH-1:0] trk_second;
    logic [CNTW-1:0]  trk_cnt;

    logic [WIDTH-1:0] live_res;
    logic             live_err;

    logic [WIDTH-1:0] res_q;
    logic [IDW-1:0]   id_q;
    logic [CNTW-1:0]  cnt_q;
    logic             err_q;

    // First set request at or after the pointer, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  p);
        logic [IDW-1:0] sel;
        logic           found;
        int             idx;
        sel   = p;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(p) + i) % NREQ;
            if (!found && r[idx]) begin
                sel   = IDW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick      = rr_pick(req, ptr);
    assign beat      = din_valid && (state == STREAM);
    assign last_beat = beat && din_last;
    assign req_drop  = !req[gidx];

    top2_tracker #(.WIDTH(WIDTH), .CNTW(CNTW)) u_trk (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != STREAM),
        .valid  (beat),
        .x      (din),
        .max    (trk_max),
        .second (trk_second),
        .count  (trk_cnt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state: a last beat ends the frame normally even if req drops with it.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|req) state_nx = STREAM;
            STREAM:  if (last_beat || req_drop) state_nx = REPORT;
            REPORT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant index, round-robin pointer and abort flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            gidx    <= '0;
            aborted <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    aborted <= 1'b0;
                    if (|req) gidx <= pick;
                end
                STREAM: begin
                    if (!last_beat && req_drop) aborted <= 1'b1;
                end
                REPORT: begin
                    ptr <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign live_res = (trk_cnt < CNTW'(2)) ? '0 : trk_second;
    assign live_err = (trk_cnt < CNTW'(2)) || aborted;

    // Capture the reported values so they hold until the next report.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_q <= '0;
            id_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (state == REPORT) begin
            res_q <= live_res;
            id_q  <= gidx;
            cnt_q <= trk_cnt;
            err_q <= live_err;
        end
    end

    // During REPORT the tracker still holds the frame, so drive results live.
    always_comb begin
        gnt          = '0;
        din_ready    = 1'b0;
        result_valid = 1'b0;
        result       = res_q;
        result_id    = id_q;
        result_cnt   = cnt_q;
        result_err   = err_q;
        if (state == STREAM) begin
            gnt       = {{(NREQ-1){1'b0}}, 1'b1} << gidx;
            din_ready = 1'b1;
        end
        if (state == REPORT) begin
            result_valid = 1'b1;
            result       = live_res;
            result_id    = gidx;
            result_cnt   = trk_cnt;
            result_err   = live_err;
        end
    end

endmodule
